// File: rtl/cache_wb_pkg.sv
// Shared types and address-geometry helpers for the write-back direct-mapped cache.
// Widths and bit positions are derived from the cache parameters by the functions below.
package cache_wb_pkg;

    localparam int BYTE_OFF_W         = 2;
    localparam int DEF_ADDR_W         = 12;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_NUM_LINES      = 8;
    localparam int DEF_WORDS_PER_LINE = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WB      = 3'd1,
        ST_FILL    = 3'd2,
        ST_RESP    = 3'd3,
        ST_FL_SCAN = 3'd4,
        ST_FL_WB   = 3'd5
    } state_e;

    function automatic int word_w_f(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_w_f(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int idx_lo_f(input int words);
        return BYTE_OFF_W + $clog2(words);
    endfunction

    function automatic int tag_lo_f(input int words, input int lines);
        return BYTE_OFF_W + $clog2(words) + $clog2(lines);
    endfunction

endpackage

// File: rtl/cache_wb_array.sv
// Tag/valid/dirty/data storage: asynchronous read, synchronous write, one word per cycle.
// Valid and dirty bits clear on reset; tag and data contents survive reset.
module cache_wb_array #(
    parameter int NUM_LINES      = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 5,
    parameter int DATA_W         = 32,
    localparam int IDX_W         = $clog2(NUM_LINES),
    localparam int WORD_W        = $clog2(WORDS_PER_LINE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic              data_we_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              meta_we_i,
    input  logic              valid_i,
    input  logic              dirty_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              valid_o,
    output logic              dirty_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0]       data_mem [NUM_LINES*WORDS_PER_LINE];
    logic [TAG_W-1:0]        tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0]    valid_q, valid_d;
    logic [NUM_LINES-1:0]    dirty_q, dirty_d;
    logic [IDX_W+WORD_W-1:0] waddr_s;

    assign waddr_s = {idx_i, word_i};

    // next-state of the per-line status bits
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (meta_we_i) begin
            valid_d[idx_i] = valid_i;
            dirty_d[idx_i] = dirty_i;
        end else begin
            valid_d = valid_q;
            dirty_d = dirty_q;
        end
    end

    // status bits with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // tag and data storage, never reset
    always_ff @(posedge clk) begin
        if (data_we_i) begin
            data_mem[waddr_s] <= data_i;
        end
        if (meta_we_i) begin
            tag_mem[idx_i] <= tag_i;
        end
    end

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_mem[idx_i];
    assign data_o  = data_mem[waddr_s];

endmodule

// File: rtl/cache_wb_dm.sv
// Direct-mapped write-back, write-allocate data cache with per-word req/ack memory
// handshake and a FLUSH command that writes every dirty line back in index order.
module cache_wb_dm
    import cache_wb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int NUM_LINES      = DEF_NUM_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              C_CSN,
    input  logic              C_WEN,
    input  logic [ADDR_W-1:0] C_ADDR,
    input  logic [DATA_W-1:0] C_DI,
    output logic [DATA_W-1:0] C_DOUT,
    output logic              STALL,
    input  logic              FLUSH,
    output logic              FLUSH_DONE,
    output logic              M_REQ,
    output logic              M_WEN,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [DATA_W-1:0] M_DOUT,
    input  logic [DATA_W-1:0] M_DI,
    input  logic              M_ACK
);

    localparam int WORD_W = word_w_f(WORDS_PER_LINE);
    localparam int IDX_W  = idx_w_f(NUM_LINES);
    localparam int IDX_LO = idx_lo_f(WORDS_PER_LINE);
    localparam int TAG_LO = tag_lo_f(WORDS_PER_LINE, NUM_LINES);
    localparam int TAG_W  = ADDR_W - TAG_LO;

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [TAG_W-1:0]   vtag_q, vtag_d;

    logic [WORD_W-1:0]  cpu_word_s;
    logic [IDX_W-1:0]   cpu_idx_s;
    logic [TAG_W-1:0]   cpu_tag_s;
    logic [IDX_W-1:0]   arr_idx_s;
    logic [WORD_W-1:0]  arr_word_s;
    logic               rd_valid_s, rd_dirty_s, hit_s;
    logic [TAG_W-1:0]   rd_tag_s;
    logic [DATA_W-1:0]  rd_data_s;

    logic               stall_s, mreq_s, mwen_s, done_s;
    logic [DATA_W-1:0]  cdout_s, mdout_s, data_wr_s;
    logic [ADDR_W-1:0]  maddr_s;
    logic               data_we_s, meta_we_s, meta_valid_s, meta_dirty_s;
    logic [TAG_W-1:0]   meta_tag_s;
    logic               unused_s;

    assign cpu_word_s = C_ADDR[IDX_LO-1:BYTE_OFF_W];
    assign cpu_idx_s  = C_ADDR[TAG_LO-1:IDX_LO];
    assign cpu_tag_s  = C_ADDR[ADDR_W-1:TAG_LO];
    assign unused_s   = ^C_ADDR[BYTE_OFF_W-1:0];
    assign hit_s      = rd_valid_s && (rd_tag_s == cpu_tag_s);

    // the array port follows the CPU in IDLE/RESP, the latched line during a miss, the pointer during flush
    always_comb begin
        arr_idx_s  = cpu_idx_s;
        arr_word_s = word_q;
        case (state_q)
            ST_IDLE:               begin arr_idx_s = cpu_idx_s; arr_word_s = cpu_word_s; end
            ST_RESP:               begin arr_idx_s = idx_q;     arr_word_s = cpu_word_s; end
            ST_WB, ST_FILL:        begin arr_idx_s = idx_q;     arr_word_s = word_q;     end
            ST_FL_SCAN, ST_FL_WB:  begin arr_idx_s = ptr_q;     arr_word_s = word_q;     end
            default:               begin arr_idx_s = cpu_idx_s; arr_word_s = word_q;     end
        endcase
    end

    cache_wb_array #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W),
        .DATA_W         (DATA_W)
    ) u_array (
        .clk       (CLK),
        .rst_n     (RSTn),
        .idx_i     (arr_idx_s),
        .word_i    (arr_word_s),
        .data_we_i (data_we_s),
        .data_i    (data_wr_s),
        .meta_we_i (meta_we_s),
        .valid_i   (meta_valid_s),
        .dirty_i   (meta_dirty_s),
        .tag_i     (meta_tag_s),
        .valid_o   (rd_valid_s),
        .dirty_o   (rd_dirty_s),
        .tag_o     (rd_tag_s),
        .data_o    (rd_data_s)
    );

    // next-state, array writes and interface outputs
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        idx_d        = idx_q;
        ptr_d        = ptr_q;
        vtag_d       = vtag_q;
        stall_s      = 1'b1;
        cdout_s      = '0;
        mreq_s       = 1'b0;
        mwen_s       = 1'b1;
        maddr_s      = '0;
        mdout_s      = '0;
        done_s       = 1'b0;
        data_we_s    = 1'b0;
        data_wr_s    = C_DI;
        meta_we_s    = 1'b0;
        meta_valid_s = rd_valid_s;
        meta_dirty_s = rd_dirty_s;
        meta_tag_s   = rd_tag_s;
        case (state_q)
            ST_IDLE: begin
                stall_s = 1'b0;
                if (!C_CSN) begin
                    if (hit_s) begin
                        if (C_WEN) begin
                            cdout_s = rd_data_s;
                        end else begin
                            data_we_s    = 1'b1;
                            meta_we_s    = 1'b1;
                            meta_dirty_s = 1'b1;
                        end
                    end else begin
                        stall_s = 1'b1;
                        idx_d   = cpu_idx_s;
                        vtag_d  = rd_tag_s;
                        word_d  = '0;
                        state_d = (rd_valid_s && rd_dirty_s) ? ST_WB : ST_FILL;
                    end
                end else if (FLUSH) begin
                    ptr_d   = '0;
                    word_d  = '0;
                    state_d = ST_FL_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB, ST_FL_WB: begin
                mreq_s  = 1'b1;
                mwen_s  = 1'b0;
                mdout_s = rd_data_s;
                if (state_q == ST_WB) begin
                    maddr_s = {vtag_q, idx_q, word_q, {BYTE_OFF_W{1'b0}}};
                end else begin
                    maddr_s = {rd_tag_s, ptr_q, word_q, {BYTE_OFF_W{1'b0}}};
                end
                if (M_ACK) begin
                    word_d = word_q + {{(WORD_W-1){1'b0}}, 1'b1};
                    if (&word_q) begin
                        if (state_q == ST_WB) begin
                            state_d = ST_FILL;
                        end else begin
                            meta_we_s    = 1'b1;
                            meta_dirty_s = 1'b0;
                            state_d      = ST_FL_SCAN;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    word_d = word_q;
                end
            end
            ST_FILL: begin
                mreq_s  = 1'b1;
                maddr_s = {cpu_tag_s, idx_q, word_q, {BYTE_OFF_W{1'b0}}};
                if (M_ACK) begin
                    data_we_s = 1'b1;
                    data_wr_s = M_DI;
                    word_d    = word_q + {{(WORD_W-1){1'b0}}, 1'b1};
                    if (&word_q) begin
                        meta_we_s    = 1'b1;
                        meta_valid_s = 1'b1;
                        meta_dirty_s = 1'b0;
                        meta_tag_s   = cpu_tag_s;
                        state_d      = ST_RESP;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    word_d = word_q;
                end
            end
            ST_RESP: begin
                stall_s = 1'b0;
                state_d = ST_IDLE;
                if (!C_CSN && !C_WEN) begin
                    data_we_s    = 1'b1;
                    meta_we_s    = 1'b1;
                    meta_valid_s = 1'b1;
                    meta_dirty_s = 1'b1;
                end else if (!C_CSN) begin
                    cdout_s = rd_data_s;
                end else begin
                    cdout_s = '0;
                end
            end
            ST_FL_SCAN: begin
                if (rd_valid_s && rd_dirty_s) begin
                    word_d  = '0;
                    state_d = ST_FL_WB;
                end else if (&ptr_q) begin
                    done_s  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    ptr_d = ptr_q + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // control state register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            vtag_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            vtag_q  <= vtag_d;
        end
    end

    assign STALL      = stall_s & RSTn;
    assign C_DOUT     = cdout_s;
    assign M_REQ      = mreq_s;
    assign M_WEN      = mwen_s;
    assign M_ADDR     = maddr_s;
    assign M_DOUT     = mdout_s;
    assign FLUSH_DONE = done_s;

endmodule

// File: tb/tb_cache_wb_dm.sv
// Directed bench for cache_wb_dm: behavioural word memory with optional ack delay,
// transfer log, and hand-computed expectations for hits, misses, write-back, flush and reset.
module tb_cache_wb_dm;

    logic        CLK, RSTn;
    logic        C_CSN, C_WEN;
    logic [11:0] C_ADDR;
    logic [31:0] C_DI, C_DOUT;
    logic        STALL, FLUSH, FLUSH_DONE;
    logic        M_REQ, M_WEN, M_ACK;
    logic [11:0] M_ADDR;
    logic [31:0] M_DOUT, M_DI;

    typedef struct packed {
        logic        wen;
        logic [11:0] addr;
        logic [31:0] data;
    } xfer_t;

    logic [31:0] mem [0:1023];
    xfer_t       xlog [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    int          stab_err  = 0;
    logic        hold_pend = 1'b0;
    logic [11:0] hold_addr = '0;
    logic        hold_wen  = 1'b1;

    cache_wb_dm dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .C_CSN      (C_CSN),
        .C_WEN      (C_WEN),
        .C_ADDR     (C_ADDR),
        .C_DI       (C_DI),
        .C_DOUT     (C_DOUT),
        .STALL      (STALL),
        .FLUSH      (FLUSH),
        .FLUSH_DONE (FLUSH_DONE),
        .M_REQ      (M_REQ),
        .M_WEN      (M_WEN),
        .M_ADDR     (M_ADDR),
        .M_DOUT     (M_DOUT),
        .M_DI       (M_DI),
        .M_ACK      (M_ACK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign M_DI  = mem[M_ADDR[11:2]];
    assign M_ACK = (ack_delay == 0) ? 1'b1 : (M_REQ && (wait_cnt == ack_delay));

    always @(posedge CLK) begin
        if (M_REQ && !M_ACK) wait_cnt <= wait_cnt + 1;
        else                 wait_cnt <= 0;
    end

    // transfer log, memory writes and request-stability watch
    always @(negedge CLK) begin
        if (M_REQ && M_ACK) begin
            xlog.push_back({M_WEN, M_ADDR, (M_WEN ? M_DI : M_DOUT)});
            if (!M_WEN) mem[M_ADDR[11:2]] = M_DOUT;
        end
        if (hold_pend && !(M_REQ && M_ADDR == hold_addr && M_WEN == hold_wen)) stab_err++;
        hold_pend = M_REQ && !M_ACK;
        hold_addr = M_ADDR;
        hold_wen  = M_WEN;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_xfer(input string tag, input int k, input logic wen, input logic [11:0] addr);
        if (k < xlog.size()) begin
            check_eq({tag, "_wen"},  32'(xlog[k].wen),  32'(wen));
            check_eq({tag, "_addr"}, 32'(xlog[k].addr), 32'(addr));
        end else begin
            check_eq({tag, "_present"}, 32'(xlog.size()), 32'(k + 1));
        end
    endtask

    task automatic cpu_access(input logic wen, input logic [11:0] addr, input logic [31:0] di,
                              output logic [31:0] dout, output int stalls);
        bit done;
        done   = 1'b0;
        stalls = 0;
        dout   = '0;
        C_CSN  = 1'b0;
        C_WEN  = wen;
        C_ADDR = addr;
        C_DI   = di;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge CLK);
            if (STALL) begin
                stalls++;
                @(posedge CLK); #1;
            end else begin
                dout = C_DOUT;
                done = 1'b1;
            end
        end
        check_eq("access_done", 32'(done), 32'd1);
        @(posedge CLK); #1;
        C_CSN = 1'b1;
        C_WEN = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        int          s, base, done_cnt;

        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        RSTn = 1'b0; C_CSN = 1'b1; C_WEN = 1'b1; C_ADDR = '0; C_DI = '0; FLUSH = 1'b0;

        #12;
        check_eq("rst_stall", 32'(STALL), 32'd0);
        check_eq("rst_cdout", C_DOUT, 32'd0);
        check_eq("rst_mreq",  32'(M_REQ), 32'd0);
        check_eq("rst_mwen",  32'(M_WEN), 32'd1);
        check_eq("rst_maddr", 32'(M_ADDR), 32'd0);
        check_eq("rst_mdout", M_DOUT, 32'd0);
        check_eq("rst_done",  32'(FLUSH_DONE), 32'd0);
        @(posedge CLK); #1; RSTn = 1'b1;
        @(posedge CLK); #1;

        // cold read miss
        base = xlog.size();
        cpu_access(1'b1, 12'h014, 32'd0, d, s);
        check_eq("cold_stall", 32'(s), 32'd5);
        check_eq("cold_data",  d, 32'hC0DE_0005);
        check_eq("cold_nxfer", 32'(xlog.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) check_xfer($sformatf("cold_fill%0d", i), base + i, 1'b1, 12'(16 + 4 * i));

        // read hit on the filled line
        base = xlog.size();
        cpu_access(1'b1, 12'h01C, 32'd0, d, s);
        check_eq("hit_stall", 32'(s), 32'd0);
        check_eq("hit_data",  d, 32'hC0DE_0007);
        check_eq("hit_nxfer", 32'(xlog.size() - base), 32'd0);

        // write hit then read it back
        cpu_access(1'b0, 12'h018, 32'hDEAD_BEEF, d, s);
        check_eq("wrhit_stall", 32'(s), 32'd0);
        cpu_access(1'b1, 12'h018, 32'd0, d, s);
        check_eq("wrhit_rdback", d, 32'hDEAD_BEEF);
        check_eq("wrhit_nxfer", 32'(xlog.size() - base), 32'd0);

        // conflicting miss with dirty victim
        base = xlog.size();
        cpu_access(1'b1, 12'h818, 32'd0, d, s);
        check_eq("wb_stall", 32'(s), 32'd9);
        check_eq("wb_data",  d, 32'hC0DE_0206);
        check_eq("wb_nxfer", 32'(xlog.size() - base), 32'd8);
        for (int i = 0; i < 4; i++) check_xfer($sformatf("wb_wr%0d", i), base + i, 1'b0, 12'(16 + 4 * i));
        for (int i = 0; i < 4; i++) check_xfer($sformatf("wb_rd%0d", i), base + 4 + i, 1'b1, 12'(12'h810 + 4 * i));
        if (base + 2 < xlog.size()) check_eq("wb_victim_word", xlog[base + 2].data, 32'hDEAD_BEEF);
        else check_eq("wb_victim_present", 32'(xlog.size()), 32'(base + 3));

        // cold read with delayed acknowledge
        ack_delay = 3;
        base = xlog.size();
        cpu_access(1'b1, 12'h024, 32'd0, d, s);
        check_eq("slow_stall", 32'(s), 32'd17);
        check_eq("slow_data",  d, 32'hC0DE_0009);
        check_eq("slow_stable", 32'(stab_err), 32'd0);
        check_eq("slow_nxfer", 32'(xlog.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) check_xfer($sformatf("slow_fill%0d", i), base + i, 1'b1, 12'(12'h020 + 4 * i));
        ack_delay = 0;
        @(posedge CLK); #1;

        // two dirty lines, then flush
        cpu_access(1'b0, 12'h814, 32'h1111_2222, d, s);
        check_eq("fl_prep1_stall", 32'(s), 32'd0);
        cpu_access(1'b0, 12'h054, 32'h3333_4444, d, s);
        check_eq("fl_prep5_stall", 32'(s), 32'd5);
        base = xlog.size();
        done_cnt = 0;
        FLUSH = 1'b1;
        for (int i = 0; i < 400 && done_cnt == 0; i++) begin
            @(negedge CLK);
            if (FLUSH_DONE) done_cnt++;
        end
        @(posedge CLK); #1;
        FLUSH = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            if (FLUSH_DONE) done_cnt++;
        end
        check_eq("fl_done_pulses", 32'(done_cnt), 32'd1);
        check_eq("fl_nxfer", 32'(xlog.size() - base), 32'd8);
        for (int i = 0; i < 4; i++) check_xfer($sformatf("fl_l1_%0d", i), base + i, 1'b0, 12'(12'h810 + 4 * i));
        for (int i = 0; i < 4; i++) check_xfer($sformatf("fl_l5_%0d", i), base + 4 + i, 1'b0, 12'(12'h050 + 4 * i));
        if (base + 5 < xlog.size()) begin
            check_eq("fl_l1_data", xlog[base + 1].data, 32'h1111_2222);
            check_eq("fl_l5_data", xlog[base + 5].data, 32'h3333_4444);
        end else begin
            check_eq("fl_data_present", 32'(xlog.size()), 32'(base + 6));
        end
        base = xlog.size();
        cpu_access(1'b1, 12'h814, 32'd0, d, s);
        check_eq("fl_hit_stall", 32'(s), 32'd0);
        check_eq("fl_hit_data",  d, 32'h1111_2222);
        check_eq("fl_hit_nxfer", 32'(xlog.size() - base), 32'd0);
        cpu_access(1'b1, 12'h014, 32'd0, d, s);
        check_eq("fl_clean_victim_stall", 32'(s), 32'd5);
        check_eq("fl_clean_victim_data",  d, 32'hC0DE_0005);

        // reset during the second fill word
        C_CSN = 1'b0; C_WEN = 1'b1; C_ADDR = 12'h064;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check_eq("mid_fill_req",  32'(M_REQ), 32'd1);
        check_eq("mid_fill_addr", 32'(M_ADDR), 32'h064);
        RSTn = 1'b0;
        #1;
        check_eq("rst_mid_req",   32'(M_REQ), 32'd0);
        check_eq("rst_mid_stall", 32'(STALL), 32'd0);
        check_eq("rst_mid_mwen",  32'(M_WEN), 32'd1);
        check_eq("rst_mid_maddr", 32'(M_ADDR), 32'd0);
        C_CSN = 1'b1;
        @(posedge CLK); #1; RSTn = 1'b1;
        @(posedge CLK); #1;
        cpu_access(1'b1, 12'h064, 32'd0, d, s);
        check_eq("post_rst_stall", 32'(s), 32'd5);
        check_eq("post_rst_data",  d, 32'hC0DE_0019);
        cpu_access(1'b1, 12'h014, 32'd0, d, s);
        check_eq("post_rst_invalid_stall", 32'(s), 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
